// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: sequences a quarter-wave sine NCO to produce one linear-chirp
// reference line per sweep trigger. It owns the NCO clock enable and reset,
// waits out the NCO pipeline fill, and tags exactly the output samples that
// belong to the line.
// Optional feature: define NCO_SWEEP_LINE_CNT_EN to enable the completed-line
// counter on line_cnt_o. Without it, line_cnt_o is tied to zero.
module nco_sweep_ctrl #(
    parameter int APR  = 32,
    parameter int CNTW = 16,
    parameter int LAT  = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [31:0]     cfg_wdata,
    input  logic            trig_i,
    input  logic            stop_i,
    input  logic            nco_valid_i,
    output logic [APR-1:0]  nco_phi_inc_o,
    output logic            nco_clken_o,
    output logic            nco_reset_n_o,
    output logic            sample_en_o,
    output logic            frame_done_o,
    output logic            busy_o,
    output logic            overrun_o,
    output logic [CNTW-1:0] line_cnt_o
);

    localparam logic [1:0]      ADDR_START = 2'd0;
    localparam logic [1:0]      ADDR_STEP  = 2'd1;
    localparam logic [1:0]      ADDR_NSAMP = 2'd2;
    localparam logic [1:0]      ADDR_CTRL  = 2'd3;
    localparam logic [CNTW-1:0] ONE_CNT    = CNTW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FLUSH,
        S_FILL,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;

    // Host-visible configuration
    logic [APR-1:0]  r_phi_start;
    logic [APR-1:0]  r_phi_step;
    logic [CNTW-1:0] r_nsamp;
    logic            r_ctrl_arm;
    logic            r_ctrl_cont;

    // Per-line shadows; START is captured directly into the increment
    // register, which then serves as the running accumulator.
    logic [APR-1:0]  r_sh_step;
    logic [CNTW-1:0] r_sh_nsamp;
    logic [CNTW-1:0] r_k;

    // Registered outputs
    logic [APR-1:0]  r_phi_inc;
    logic            r_clken;
    logic            r_nco_rst_n;
    logic            r_frame_done;
    logic            r_busy;
    logic            r_overrun;

    logic            r_trig_d;
    logic [LAT-1:0]  r_tag;
    logic [LAT-1:0]  w_tag_next;

    logic            w_trig_rise;
    logic            w_accept;
    logic            w_done_enter;
    logic            w_ovr_evt;
    logic            w_arm_clr;
    logic            w_tag_in;

    assign w_trig_rise  = trig_i & ~r_trig_d;
    assign w_accept     = (r_state == S_ARM) & w_trig_rise & ~stop_i;
    // A line ends either immediately (empty line) or once the tag pipe drains.
    assign w_done_enter = ~stop_i &
                          ((w_accept & (r_nsamp == '0)) |
                           ((r_state == S_DRAIN) & (w_tag_next == '0)));
    // Triggers while a line is in flight are dropped and flagged; stop masks them.
    assign w_ovr_evt    = w_trig_rise & ~stop_i &
                          (r_state != S_IDLE) & (r_state != S_ARM);
    // Arm drops on abort, and at line end unless continuous re-arm applies.
    assign w_arm_clr    = stop_i |
                          ((r_state == S_DONE) & ~(r_ctrl_cont & r_ctrl_arm));
    assign w_tag_in     = (r_state == S_RUN);

    // Tag pipe mirrors the NCO latency: a 1 enters with each issued increment.
    assign w_tag_next[0] = w_tag_in;
    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_tag
            assign w_tag_next[gi] = r_tag[gi-1];
        end
    endgenerate

    // Trigger edge detector
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_trig_d <= 1'b0;
        end else begin
            r_trig_d <= trig_i;
        end
    end

    // Configuration registers; FSM-driven arm clear has priority over a write
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phi_start <= '0;
            r_phi_step  <= '0;
            r_nsamp     <= '0;
            r_ctrl_arm  <= 1'b0;
            r_ctrl_cont <= 1'b0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_START: r_phi_start <= APR'(cfg_wdata);
                    ADDR_STEP:  r_phi_step  <= APR'(cfg_wdata);
                    ADDR_NSAMP: r_nsamp     <= CNTW'(cfg_wdata);
                    ADDR_CTRL: begin
                        r_ctrl_arm  <= cfg_wdata[0];
                        r_ctrl_cont <= cfg_wdata[1];
                    end
                    default: ;
                endcase
            end
            if (w_arm_clr) begin
                r_ctrl_arm <= 1'b0;
            end
        end
    end

    // Sticky overrun; a new event beats a simultaneous clear request
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_evt) begin
            r_overrun <= 1'b1;
        end else if (cfg_we && (cfg_addr == ADDR_CTRL) && cfg_wdata[2]) begin
            r_overrun <= 1'b0;
        end
    end

    // Sample tag shift register, flushed on abort
    always_ff @(posedge clk) begin
        if (!reset_n || stop_i) begin
            r_tag <= '0;
        end else begin
            r_tag <= w_tag_next;
        end
    end

    // Line sequencer with registered NCO controls and status
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_phi_inc    <= '0;
            r_clken      <= 1'b0;
            r_nco_rst_n  <= 1'b1;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_sh_step    <= '0;
            r_sh_nsamp   <= '0;
            r_k          <= '0;
        end else begin
            r_frame_done <= w_done_enter;
            r_nco_rst_n  <= 1'b1;
            if (stop_i) begin
                r_state <= S_IDLE;
                r_clken <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_ctrl_arm) begin
                            r_state <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        if (w_accept) begin
                            r_phi_inc  <= r_phi_start;
                            r_sh_step  <= r_phi_step;
                            r_sh_nsamp <= r_nsamp;
                            r_k        <= '0;
                            r_busy     <= 1'b1;
                            if (r_nsamp == '0) begin
                                r_state <= S_DONE;
                            end else begin
                                r_state     <= S_FLUSH;
                                r_nco_rst_n <= 1'b0;
                            end
                        end
                    end
                    S_FLUSH: begin
                        r_state <= S_FILL;
                        r_clken <= 1'b1;
                    end
                    S_FILL: begin
                        if (nco_valid_i) begin
                            r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        // Last increment stays on the bus while the pipe drains
                        if (r_k == r_sh_nsamp - ONE_CNT) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_phi_inc <= r_phi_inc + r_sh_step;
                            r_k       <= r_k + ONE_CNT;
                        end
                    end
                    S_DRAIN: begin
                        if (w_tag_next == '0) begin
                            r_state <= S_DONE;
                            r_clken <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        r_busy <= 1'b0;
                        if (r_ctrl_cont && r_ctrl_arm) begin
                            r_state <= S_ARM;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_clken <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef NCO_SWEEP_LINE_CNT_EN
    logic [CNTW-1:0] r_line_cnt;

    // Completed-line counter, wraps naturally, cleared by reset only
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_line_cnt <= '0;
        end else if (w_done_enter) begin
            r_line_cnt <= r_line_cnt + ONE_CNT;
        end
    end

    assign line_cnt_o = r_line_cnt;
`else
    assign line_cnt_o = '0;
`endif

    assign nco_phi_inc_o = r_phi_inc;
    assign nco_clken_o   = r_clken;
    assign nco_reset_n_o = r_nco_rst_n;
    assign sample_en_o   = r_tag[LAT-1];
    assign frame_done_o  = r_frame_done;
    assign busy_o        = r_busy;
    assign overrun_o     = r_overrun;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: scoreboard bench for nco_sweep_ctrl with an attached
// behavioural NCO (LAT-deep enabled pipeline for data and valid).
`timescale 1ns/1ps
module tb_nco_sweep_ctrl;

    localparam int APR  = 32;
    localparam int CNTW = 16;
    localparam int LAT  = 10;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            cfg_we = 1'b0;
    logic [1:0]      cfg_addr = 2'd0;
    logic [31:0]     cfg_wdata = 32'd0;
    logic            trig_i = 1'b0;
    logic            stop_i = 1'b0;
    logic            nco_valid_i;
    logic [APR-1:0]  nco_phi_inc_o;
    logic            nco_clken_o;
    logic            nco_reset_n_o;
    logic            sample_en_o;
    logic            frame_done_o;
    logic            busy_o;
    logic            overrun_o;
    logic [CNTW-1:0] line_cnt_o;

    nco_sweep_ctrl #(.APR(APR), .CNTW(CNTW), .LAT(LAT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .trig_i        (trig_i),
        .stop_i        (stop_i),
        .nco_valid_i   (nco_valid_i),
        .nco_phi_inc_o (nco_phi_inc_o),
        .nco_clken_o   (nco_clken_o),
        .nco_reset_n_o (nco_reset_n_o),
        .sample_en_o   (sample_en_o),
        .frame_done_o  (frame_done_o),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o),
        .line_cnt_o    (line_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural NCO: output appears LAT enabled cycles after its input
    logic [APR-1:0] nco_data [LAT];
    logic [LAT-1:0] nco_vpipe = '0;
    always @(posedge clk) begin
        if (!reset_n || !nco_reset_n_o) begin
            nco_vpipe <= '0;
            for (int i = 0; i < LAT; i++) nco_data[i] <= '0;
        end else if (nco_clken_o) begin
            nco_vpipe <= {nco_vpipe[LAT-2:0], 1'b1};
            nco_data[0] <= nco_phi_inc_o;
            for (int i = 1; i < LAT; i++) nco_data[i] <= nco_data[i-1];
        end
    end
    assign nco_valid_i = nco_vpipe[LAT-1];

    typedef struct {
        int             cyc;
        logic [APR-1:0] inc;
    } samp_t;
    typedef struct {
        int              cyc;
        int              n;
        logic [CNTW-1:0] lc;
    } frame_t;

    samp_t  sq[$];
    frame_t fq[$];

    int checks = 0;
    int errors = 0;

    // Model of the host-visible registers and of completed lines
    logic [31:0] m_start = '0;
    logic [31:0] m_step  = '0;
    int          m_nsamp = 0;
    int          m_lines = 0;

    function automatic logic [CNTW-1:0] exp_lc();
`ifdef NCO_SWEEP_LINE_CNT_EN
        return CNTW'(m_lines);
`else
        return '0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a sample or a frame end
    always @(negedge clk) begin
        if (reset_n) begin
            if (sample_en_o) begin
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    samp_t s;
                    s = sq.pop_front();
                    chk("sample_cycle", 64'(cyc), 64'(s.cyc));
                    chk("sample_inc", 64'(nco_data[LAT-1]), 64'(s.inc));
                end
            end
            if (frame_done_o) begin
                if (fq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_done actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    frame_t f;
                    f = fq.pop_front();
                    chk("frame_cycle", 64'(cyc), 64'(f.cyc));
                    chk("line_cnt", 64'(line_cnt_o), 64'(f.lc));
                    chk("samples_left", 64'(sq.size()), 64'd0);
                    $display("frame done cycle=%0d nsamp=%0d line_cnt=%0d", cyc, f.n, line_cnt_o);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        step(1);
        cfg_we = 1'b0;
        case (a)
            2'd0: m_start = d;
            2'd1: m_step  = d;
            2'd2: m_nsamp = int'(d[CNTW-1:0]);
            default: ;
        endcase
    endtask

    task automatic setup_line(input logic [31:0] st, input logic [31:0] sp,
                              input int n, input logic [31:0] ctrl);
        cfg_write(2'd0, st);
        cfg_write(2'd1, sp);
        cfg_write(2'd2, 32'(n));
        cfg_write(2'd3, ctrl);
        step(2);
    endtask

    // One-cycle trigger pulse; when the model accepts it, the line's
    // increments and end time are derived from the register snapshot.
    task automatic fire_trigger(input bit accepted);
        int     t;
        frame_t f;
        t = cyc;
        trig_i = 1'b1;
        if (accepted) begin
            for (int k = 0; k < m_nsamp; k++) begin
                samp_t s;
                s.cyc = t + 3 + 2 * LAT + k;
                s.inc = m_start + m_step * 32'(k);
                sq.push_back(s);
            end
            m_lines++;
            f.cyc = (m_nsamp == 0) ? t + 1 : t + 3 + 2 * LAT + m_nsamp;
            f.n   = m_nsamp;
            f.lc  = exp_lc();
            fq.push_back(f);
        end
        $display("trigger cycle=%0d accepted=%0d start=0x%08h step=0x%08h nsamp=%0d",
                 t, accepted, m_start, m_step, m_nsamp);
        step(1);
        trig_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        step(1);
        stop_i = 1'b0;
    endtask

    task automatic wait_frames(input int budget);
        int n;
        n = 0;
        while (fq.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (fq.size() != 0) begin
            errors++;
            $display("FAIL frame_timeout actual=%0d_pending required=0", fq.size());
            fq.delete();
            sq.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        step(4);
        chk("rst_phi_inc", 64'(nco_phi_inc_o), 64'd0);
        chk("rst_clken", 64'(nco_clken_o), 64'd0);
        chk("rst_nco_reset_n", 64'(nco_reset_n_o), 64'd1);
        chk("rst_sample_en", 64'(sample_en_o), 64'd0);
        chk("rst_frame_done", 64'(frame_done_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_overrun", 64'(overrun_o), 64'd0);
        chk("rst_line_cnt", 64'(line_cnt_o), 64'd0);
        reset_n = 1'b1;
        step(2);

        // Basic single line, then a trigger while idle must be ignored
        setup_line(32'h0100_0000, 32'h10, 4, 32'h1);
        fire_trigger(1'b1);
        wait_frames(200);
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_clken", 64'(nco_clken_o), 64'd0);
        fire_trigger(1'b0);
        step(40);
        chk("idle_trig_overrun", 64'(overrun_o), 64'd0);
        chk("idle_trig_busy", 64'(busy_o), 64'd0);

        // Increment wrap-around
        setup_line(32'hFFFF_FFF0, 32'h10, 3, 32'h1);
        fire_trigger(1'b1);
        wait_frames(200);

        // Continuous mode with an overrunning trigger in RUN
        setup_line($urandom(), $urandom(), 8, 32'h3);
        fire_trigger(1'b1);
        step(14);
        fire_trigger(1'b0);
        step(1);
        chk("overrun_set", 64'(overrun_o), 64'd1);
        wait_frames(200);
        chk("overrun_sticky", 64'(overrun_o), 64'd1);
        chk("rearm_busy", 64'(busy_o), 64'd0);
        cfg_write(2'd0, $urandom());
        fire_trigger(1'b1);
        step(5);
        cfg_write(2'd3, 32'h7);
        step(1);
        chk("overrun_cleared", 64'(overrun_o), 64'd0);
        wait_frames(200);
        pulse_stop();
        cfg_write(2'd3, 32'h0);
        chk("cont_stop_busy", 64'(busy_o), 64'd0);

        // Abort mid-RUN
        setup_line($urandom(), $urandom(), 8, 32'h1);
        fire_trigger(1'b1);
        step(14);
        sq.delete();
        fq.delete();
        m_lines--;
        pulse_stop();
        chk("stop_busy", 64'(busy_o), 64'd0);
        chk("stop_clken", 64'(nco_clken_o), 64'd0);
        chk("stop_sample_en", 64'(sample_en_o), 64'd0);
        step(40);
        chk("stop_line_cnt", 64'(line_cnt_o), 64'(exp_lc()));
        fire_trigger(1'b0);
        step(30);
        chk("stop_disarmed", 64'(busy_o), 64'd0);

        // Empty line
        setup_line($urandom(), $urandom(), 0, 32'h1);
        fire_trigger(1'b1);
        chk("empty_clken", 64'(nco_clken_o), 64'd0);
        chk("empty_no_flush", 64'(nco_reset_n_o), 64'd1);
        chk("empty_busy", 64'(busy_o), 64'd1);
        wait_frames(20);

        // START written during RUN applies to the following line only
        setup_line(32'h1, $urandom(), 6, 32'h1);
        fire_trigger(1'b1);
        step(14);
        cfg_write(2'd0, 32'h5);
        wait_frames(200);
        cfg_write(2'd3, 32'h1);
        step(2);
        fire_trigger(1'b1);
        wait_frames(200);

        // Randomised lines
        for (int i = 0; i < 6; i++) begin
            setup_line($urandom(), $urandom(), int'($urandom_range(1, 12)), 32'h1);
            fire_trigger(1'b1);
            wait_frames(200);
        end

        step(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
